// File: rtl/multdiv_ctrl_if.sv
// ---------------------------------------------------------------------------
// multdiv_ctrl_if
// Bundle between the DX/XM pipeline logic and the multiply/divide sequencer.
//
// Handshake: ctrl_mult / ctrl_div are start requests that the sequencer looks
// at only while idle. A start is accepted on the rising edge that sees it
// while idle and no flush is present. Operands are captured on that same edge.
// There is no back-pressure. The result side is a valid-only channel:
// data_result / data_exception are valid in the single cycle that
// data_resultRDY is high, and the consumer must take them in that cycle.
// stall is high for the whole time the sequencer is iterating.
//
// Signals:
//   ctrl_mult, ctrl_div, ctrl_flush   pipeline -> sequencer control
//   data_operandA, data_operandB      operands (multiplicand/dividend, multiplier/divisor)
//   data_result, data_exception       result word and overflow / divide-by-zero flag
//   data_resultRDY                    one-cycle result-valid pulse
//   stall                             pipeline stall request
// ---------------------------------------------------------------------------
interface multdiv_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             ctrl_mult;
    logic             ctrl_div;
    logic             ctrl_flush;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             stall;

    // Pipeline side: issues requests, consumes results.
    modport master (
        output ctrl_mult, ctrl_div, ctrl_flush, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY, stall
    );

    // Sequencer side.
    modport slave (
        input  ctrl_mult, ctrl_div, ctrl_flush, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY, stall
    );
endinterface

// File: rtl/multdiv_ctrl.sv
// ---------------------------------------------------------------------------
// multdiv_ctrl
// Iterative signed multiply / divide sequencer for the execute stage.
// Multiply: shift-add on operand magnitudes, one multiplier bit per edge.
// Divide:   restoring division on magnitudes, one quotient bit per edge.
// The result is sign-corrected at the end and presented for one cycle together
// with data_resultRDY.
//
// Optional feature macro: MULTDIV_RADIX4_EN
//   When it is defined, multiply uses radix-4 Booth recoding on the signed
//   operands (two multiplier bits per edge, WIDTH/2 edges). Divide is
//   unaffected.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-low reset
//   bus        multdiv_ctrl_if.slave (controls, operands, result, stall)
//   dbg_state  current FSM state (0 IDLE, 1 MULT, 2 DIV, 3 DONE)
// ---------------------------------------------------------------------------
module multdiv_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                clock,
    input  logic                reset,
    multdiv_ctrl_if.slave       bus,
    output logic [1:0]          dbg_state
);
    localparam int DW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

`ifdef MULTDIV_RADIX4_EN
    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(WIDTH / 2 - 1);
`else
    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(WIDTH - 1);
`endif
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d;       // result must be negated
    logic             ovf_q, ovf_d;       // most-negative / -1 divide
    // mcand: multiplicand shifted left each step (mult) / divisor in low bits (div)
    logic [DW-1:0]    mcand_q, mcand_d;
    // mplier: multiplier consumed from the LSB (mult) / dividend becoming quotient (div)
    logic [WIDTH-1:0] mplier_q, mplier_d;
    // acc: product accumulator (mult) / partial remainder in low bits (div)
    logic [DW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;
`ifdef MULTDIV_RADIX4_EN
    logic             booth_prev_q, booth_prev_d;
    logic [DW-1:0]    booth_term;
`endif

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [DW-1:0]    mult_sum, mult_sp;
    logic [WIDTH:0]   mult_hi;
    logic             mult_exc;
    logic [WIDTH:0]   div_rem_sh, div_dvsr;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem_nx, div_q_nx;
    logic [CNT_W-1:0] cnt_inc;

    assign a_mag = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
    assign b_mag = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

`ifdef MULTDIV_RADIX4_EN
    // Booth digit from {b[2i+1], b[2i], b[2i-1]}; accumulating in two's
    // complement yields the signed product directly.
    always_comb begin
        booth_term = '0;
        case ({mplier_q[1:0], booth_prev_q})
            3'b001, 3'b010: booth_term = mcand_q;
            3'b011:         booth_term = mcand_q << 1;
            3'b100:         booth_term = -(mcand_q << 1);
            3'b101, 3'b110: booth_term = -mcand_q;
            default:        booth_term = '0;
        endcase
    end
    assign mult_sum = acc_q + booth_term;
    assign mult_sp  = mult_sum;
`else
    assign mult_sum = acc_q + (mplier_q[0] ? mcand_q : {DW{1'b0}});
    assign mult_sp  = neg_q ? -mult_sum : mult_sum;
`endif
    // Product fits in WIDTH signed bits only if bits [DW-1:WIDTH-1] agree.
    assign mult_hi  = mult_sp[DW-1:WIDTH-1];
    assign mult_exc = !((&mult_hi) || !(|mult_hi));

    // Restoring divide step: shift in next dividend bit, subtract if it fits.
    assign div_rem_sh = {acc_q[WIDTH-1:0], mplier_q[WIDTH-1]};
    assign div_dvsr   = {1'b0, mcand_q[WIDTH-1:0]};
    assign div_ge     = div_rem_sh >= div_dvsr;
    assign div_rem_nx = div_ge ? WIDTH'(div_rem_sh - div_dvsr) : div_rem_sh[WIDTH-1:0];
    assign div_q_nx   = {mplier_q[WIDTH-2:0], div_ge};

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;
`ifdef MULTDIV_RADIX4_EN
        booth_prev_d = booth_prev_q;
`endif
        case (state_q)
            S_IDLE: begin
                // Flush beats a same-cycle start; mult beats div.
                if (!bus.ctrl_flush && bus.ctrl_mult) begin
                    state_d = S_MULT;
                    cnt_d   = '0;
                    neg_d   = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                    acc_d   = '0;
`ifdef MULTDIV_RADIX4_EN
                    mcand_d      = {{WIDTH{bus.data_operandA[WIDTH-1]}}, bus.data_operandA};
                    mplier_d     = bus.data_operandB;
                    booth_prev_d = 1'b0;
`else
                    mcand_d  = {{WIDTH{1'b0}}, a_mag};
                    mplier_d = b_mag;
`endif
                end else if (!bus.ctrl_flush && bus.ctrl_div) begin
                    if (bus.data_operandB == '0) begin
                        // Divide by zero: no iterations, report at once.
                        state_d  = S_DONE;
                        result_d = '0;
                        exc_d    = 1'b1;
                        rdy_d    = 1'b1;
                    end else begin
                        state_d  = S_DIV;
                        cnt_d    = '0;
                        neg_d    = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                        ovf_d    = (bus.data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                                   (&bus.data_operandB);
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, b_mag};
                        mplier_d = a_mag;
                    end
                end
            end
            S_MULT: begin
                if (bus.ctrl_flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = mult_sum;
                    cnt_d = cnt_inc;
`ifdef MULTDIV_RADIX4_EN
                    mcand_d      = mcand_q << 2;
                    mplier_d     = mplier_q >> 2;
                    booth_prev_d = mplier_q[1];
`else
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
`endif
                    if (cnt_q == MULT_LAST) begin
                        state_d  = S_DONE;
                        result_d = mult_sp[WIDTH-1:0];
                        exc_d    = mult_exc;
                        rdy_d    = 1'b1;
                    end
                end
            end
            S_DIV: begin
                if (bus.ctrl_flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d    = {{WIDTH{1'b0}}, div_rem_nx};
                    mplier_d = div_q_nx;
                    cnt_d    = cnt_inc;
                    if (cnt_q == DIV_LAST) begin
                        state_d  = S_DONE;
                        // Quotient magnitude 2^(WIDTH-1) with no negation already
                        // gives the most-negative pattern for the overflow case.
                        result_d = neg_q ? -div_q_nx : div_q_nx;
                        exc_d    = ovf_q;
                        rdy_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
`ifdef MULTDIV_RADIX4_EN
            booth_prev_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
`ifdef MULTDIV_RADIX4_EN
            booth_prev_q <= booth_prev_d;
`endif
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.stall          = (state_q == S_MULT) || (state_q == S_DIV);
    assign dbg_state          = state_q;
endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: vector table, corner sequences,
// and random operations against an arithmetic reference model.
module tb_multdiv_ctrl;
    localparam int W = 32;
`ifdef MULTDIV_RADIX4_EN
    localparam int LAT_M = 16;
`else
    localparam int LAT_M = 32;
`endif
    localparam int LAT_D = 32;

    logic       clock;
    logic       reset;
    logic [1:0] dbg_state;

    multdiv_ctrl_if #(.WIDTH(W)) bus ();

    multdiv_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [W:0] exp_q[$];        // {exception, result}
    logic [W-1:0] last_res = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Every ready pulse is matched against the oldest expected completion.
    always @(posedge clock) begin
        #1;
        if (reset && bus.data_resultRDY) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready actual=%0h expected=none", bus.data_result);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                check("result", 64'({bus.data_exception, bus.data_result}), 64'(e));
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [W:0] model(input logic is_div, input logic [W-1:0] a, input logic [W-1:0] b);
        longint p;
        int sa, sb, q;
        if (!is_div) begin
            p = longint'(signed'(a)) * longint'(signed'(b));
            return {p != longint'(int'(p[31:0])), p[31:0]};
        end
        if (b == 0) return {1'b1, 32'h0};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
        sa = a;
        sb = b;
        q  = sa / sb;
        return {1'b0, 32'(q)};
    endfunction

    // ---------------- driver ----------------
    task automatic run_op(input logic is_div, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] er, input logic ee, input int lat, input string name);
        int k, stall_cnt;
        bit seen;
        bus.ctrl_mult     = !is_div;
        bus.ctrl_div      = is_div;
        bus.data_operandA = a;
        bus.data_operandB = b;
        exp_q.push_back({ee, er});
        tick();                              // E0
        bus.ctrl_mult     = 1'b0;
        bus.ctrl_div      = 1'b0;
        bus.data_operandA = $urandom;        // operands must already be captured
        bus.data_operandB = $urandom;
        k = 0; stall_cnt = 0; seen = 0;
        while (!seen && k < 100) begin
            if (bus.data_resultRDY) seen = 1;
            else begin
                if (bus.stall) stall_cnt++;
                tick();
                k++;
            end
        end
        check({name, "_latency"}, 64'(k), 64'(lat));
        check({name, "_stall_cycles"}, 64'(stall_cnt), 64'(lat));
        tick();
        check({name, "_ready_one_cycle"}, 64'(bus.data_resultRDY), 64'(0));
        last_res = er;
    endtask

    typedef struct {
        logic        is_div;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic        exp_exc;
        int          exp_lat;
        string       name;
    } vec_t;

    vec_t vecs[11];
    logic [31:0] edge_vals[5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 200)) - 32'd100;
            2:       return edge_vals[$urandom_range(0, 4)];
            default: return 32'($urandom_range(0, 65535));
        endcase
    endfunction

    // ---------------- test ----------------
    initial begin
        int pulses, first;
        vecs[0]  = '{1'b0, 32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0, LAT_M, "mul_7_m6"};
        vecs[1]  = '{1'b0, 32'h4000_0000,  32'd4,         32'h0000_0000, 1'b1, LAT_M, "mul_ovf"};
        vecs[2]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0, LAT_D, "div_m7_2"};
        vecs[3]  = '{1'b1, 32'd100,        32'd0,         32'h0000_0000, 1'b1, 0,     "div_by_zero"};
        vecs[4]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1, LAT_D, "div_min_m1"};
        vecs[5]  = '{1'b0, 32'd3,          32'd4,         32'd12,        1'b0, LAT_M, "mul_3_4"};
        vecs[6]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,         1'b0, LAT_M, "mul_m1_m1"};
        vecs[7]  = '{1'b0, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0, LAT_M, "mul_min_1"};
        vecs[8]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1, LAT_M, "mul_min_m1"};
        vecs[9]  = '{1'b1, 32'd7,          32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0, LAT_D, "div_7_m7"};
        vecs[10] = '{1'b1, 32'h7FFF_FFFF,  32'd1,         32'h7FFF_FFFF, 1'b0, LAT_D, "div_max_1"};

        reset = 1'b0;
        bus.ctrl_mult = 1'b0; bus.ctrl_div = 1'b0; bus.ctrl_flush = 1'b0;
        bus.data_operandA = '0; bus.data_operandB = '0;
        tick();
        check("reset_state", 64'(dbg_state), 64'(0));
        check("reset_outputs", 64'({bus.stall, bus.data_resultRDY, bus.data_exception, bus.data_result}), 64'(0));
        tick();
        reset = 1'b1;
        tick();

        for (int i = 0; i < 11; i++)
            run_op(vecs[i].is_div, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].exp_exc,
                   vecs[i].exp_lat, vecs[i].name);

        // Reset in the middle of a multiply, then a clean 3*4.
        bus.ctrl_mult = 1'b1; bus.data_operandA = 32'd1234; bus.data_operandB = 32'd5678;
        tick();
        bus.ctrl_mult = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        #2 reset = 1'b0;
        #1;
        check("midop_reset_outputs", 64'({bus.stall, bus.data_resultRDY, bus.data_exception, bus.data_result}), 64'(0));
        tick();
        reset = 1'b1;
        run_op(1'b0, 32'd3, 32'd4, 32'd12, 1'b0, LAT_M, "post_reset_mul");

        // Mult and div together: mult wins; a later div pulse is ignored.
        bus.ctrl_mult = 1'b1; bus.ctrl_div = 1'b1;
        bus.data_operandA = 32'd5; bus.data_operandB = 32'd5;
        exp_q.push_back({1'b0, 32'd25});
        tick();                              // E0
        bus.ctrl_mult = 1'b0; bus.ctrl_div = 1'b0;
        pulses = 0; first = -1;
        for (int k = 0; k < 45; k++) begin
            if (bus.data_resultRDY) begin
                pulses++;
                if (first < 0) first = k;
            end
            bus.ctrl_div = (k == 4);         // high across E5
            tick();
        end
        bus.ctrl_div = 1'b0;
        check("both_start_pulses", 64'(pulses), 64'(1));
        check("both_start_latency", 64'(first), 64'(LAT_M));
        last_res = 32'd25;

        // Flush a divide at E12.
        bus.ctrl_div = 1'b1; bus.data_operandA = 32'd1000; bus.data_operandB = 32'd3;
        tick();                              // E0
        bus.ctrl_div = 1'b0;
        for (int i = 0; i < 11; i++) tick(); // E1..E11
        bus.ctrl_flush = 1'b1;
        tick();                              // E12
        bus.ctrl_flush = 1'b0;
        check("flush_stall", 64'(bus.stall), 64'(0));
        check("flush_result_held", 64'(bus.data_result), 64'(last_res));
        check("flush_no_ready", 64'(bus.data_resultRDY), 64'(0));
        run_op(1'b0, 32'd9, 32'hFFFF_FFF7, 32'hFFFF_FFAF, 1'b0, LAT_M, "post_flush_mul");

        // Flush in IDLE drops a same-cycle start.
        bus.ctrl_flush = 1'b1; bus.ctrl_mult = 1'b1;
        tick();
        bus.ctrl_flush = 1'b0; bus.ctrl_mult = 1'b0;
        check("idle_flush_state", 64'({dbg_state, bus.stall}), 64'(0));
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.data_resultRDY) pulses++;
            tick();
        end
        check("idle_flush_no_ready", 64'(pulses), 64'(0));

        // Random operations against the model.
        for (int i = 0; i < 40; i++) begin
            logic        d;
            logic [31:0] a, b;
            logic [32:0] m;
            d = 1'($urandom_range(0, 1));
            a = rand_op();
            b = rand_op();
            m = model(d, a, b);
            run_op(d, a, b, m[31:0], m[32], d ? ((b == 0) ? 0 : LAT_D) : LAT_M,
                   d ? "rand_div" : "rand_mul");
        end

        tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
